// File: rtl/score_keeper.sv
// PS/2 scan-code driven BCD score keeper: parses make/break/extended codes,
// keeps a saturating BCD score plus a running high score.
module score_keeper #(
    parameter int          DIGITS   = 4,
    parameter logic [7:0]  INC_CODE = 8'h1D,
    parameter logic [7:0]  DEC_CODE = 8'h1B,
    parameter int          STEP     = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [7:0]            key_data,
    input  logic                  key_valid,
    input  logic                  enable,
    input  logic                  clear_score,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic [7:0]            last_make,
    output logic                  score_pulse,
    output logic                  new_high,
    output logic                  sat
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BREAK     = 2'd1,
        EXT       = 2'd2,
        EXT_BREAK = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           make_plain;
    logic           make_ext;
    logic           do_inc;
    logic           do_dec;
    logic [W-1:0]   score_next;

    function automatic logic [W-1:0] bcd_add(input logic [W-1:0] v);
        logic [W-1:0] r;
        int           d;
        int           c;
        r = '0;
        c = STEP;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(v[4*i +: 4]) + c;
            if (d > 9) begin
                d = d - 10;
                c = 1;
            end else begin
                c = 0;
            end
            r[4*i +: 4] = 4'(d);
        end
        // Carry out of the top digit means the true result exceeds all nines.
        if (c != 0) r = ALL_NINES;
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] v);
        logic [W-1:0] r;
        int           d;
        int           b;
        r = '0;
        b = STEP;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(v[4*i +: 4]) - b;
            if (d < 0) begin
                d = d + 10;
                b = 1;
            end else begin
                b = 0;
            end
            r[4*i +: 4] = 4'(d);
        end
        if (b != 0) r = '0;
        return r;
    endfunction

    // Parser next-state; make_* flag the byte as a make code for this cycle.
    always_comb begin
        state_next = state;
        make_plain = 1'b0;
        make_ext   = 1'b0;
        if (key_valid) begin
            case (state)
                IDLE: begin
                    if (key_data == BREAK_CODE)     state_next = BREAK;
                    else if (key_data == EXT_CODE)  state_next = EXT;
                    else                            make_plain = 1'b1;
                end
                BREAK:     state_next = IDLE;
                EXT: begin
                    if (key_data == BREAK_CODE) begin
                        state_next = EXT_BREAK;
                    end else begin
                        make_ext   = 1'b1;
                        state_next = IDLE;
                    end
                end
                EXT_BREAK: state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        do_inc     = make_plain && enable && (key_data == INC_CODE);
        do_dec     = make_plain && enable && (key_data == DEC_CODE) && !do_inc;
        score_next = score_bcd;
        if (clear_score)  score_next = '0;
        else if (do_inc)  score_next = bcd_add(score_bcd);
        else if (do_dec)  score_next = bcd_sub(score_bcd);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            score_bcd   <= '0;
            high_bcd    <= '0;
            last_make   <= '0;
            score_pulse <= 1'b0;
            new_high    <= 1'b0;
        end else begin
            state       <= state_next;
            score_bcd   <= score_next;
            score_pulse <= (score_next != score_bcd);
            if (make_plain || make_ext) last_make <= key_data;
            // Packed BCD orders the same as binary, so a plain compare works.
            if (score_bcd > high_bcd) high_bcd <= score_bcd;
            if (clear_score)                new_high <= 1'b0;
            else if (score_bcd > high_bcd)  new_high <= 1'b1;
        end
    end

    assign sat = (score_bcd == ALL_NINES);

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a 4-digit STEP=1 instance and a 2-digit
// STEP=5 instance share stimulus; expected scores go through a queue.
module tb_score_keeper;

    logic        clk;
    logic        reset;
    logic [7:0]  key_data;
    logic        key_valid;
    logic        enable;
    logic        clear_score;

    logic [15:0] score4, high4;
    logic [7:0]  last4;
    logic        pulse4, nh4, sat4;
    logic [7:0]  score2, high2;
    logic [7:0]  last2;
    logic        pulse2, nh2, sat2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] exp_q[$];
    logic [8:0]  exp2_q[$];

    score_keeper #(.DIGITS(4), .STEP(1)) dut4 (
        .CLOCK_50(clk), .reset(reset), .key_data(key_data), .key_valid(key_valid),
        .enable(enable), .clear_score(clear_score), .score_bcd(score4),
        .high_bcd(high4), .last_make(last4), .score_pulse(pulse4),
        .new_high(nh4), .sat(sat4)
    );

    score_keeper #(.DIGITS(2), .STEP(5)) dut2 (
        .CLOCK_50(clk), .reset(reset), .key_data(key_data), .key_valid(key_valid),
        .enable(enable), .clear_score(clear_score), .score_bcd(score2),
        .high_bcd(high2), .last_make(last2), .score_pulse(pulse2),
        .new_high(nh2), .sat(sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic v, input logic [7:0] code, input logic clr);
        @(negedge clk);
        key_valid   = v;
        key_data    = code;
        clear_score = clr;
        @(negedge clk);
        key_valid   = 1'b0;
        clear_score = 1'b0;
    endtask

    task automatic step4(input logic v, input logic [7:0] code, input logic clr,
                         input logic [15:0] exp_score, input logic exp_pulse);
        logic [16:0] e;
        exp_q.push_back({exp_pulse, exp_score});
        send(v, code, clr);
        e = exp_q.pop_front();
        check("score4", 32'(score4), 32'(e[15:0]));
        check("pulse4", 32'(pulse4), 32'(e[16]));
    endtask

    task automatic step2(input logic [7:0] code, input logic [7:0] exp_score,
                         input logic exp_pulse);
        logic [8:0] e;
        exp2_q.push_back({exp_pulse, exp_score});
        send(1'b1, code, 1'b0);
        e = exp2_q.pop_front();
        check("score2", 32'(score2), 32'(e[7:0]));
        check("pulse2", 32'(pulse2), 32'(e[8]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int e;
        reset       = 1'b1;
        key_data    = 8'h00;
        key_valid   = 1'b0;
        enable      = 1'b1;
        clear_score = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_score", 32'(score4), 32'h0);
        check("rst_high", 32'(high4), 32'h0);
        check("rst_last", 32'(last4), 32'h0);
        check("rst_pulse", 32'(pulse4), 32'h0);
        check("rst_new_high", 32'(nh4), 32'h0);
        check("rst_sat", 32'(sat4), 32'h0);

        // Make, break prefix, discarded break byte
        step4(1'b1, 8'h1D, 1'b0, 16'h0001, 1'b1);
        check("last_1d", 32'(last4), 32'h1D);
        step4(1'b1, 8'hF0, 1'b0, 16'h0001, 1'b0);
        step4(1'b1, 8'h1D, 1'b0, 16'h0001, 1'b0);
        check("last_after_break", 32'(last4), 32'h1D);

        // Extended make updates last_make only; extended break is discarded
        step4(1'b1, 8'h22, 1'b0, 16'h0001, 1'b0);
        check("last_22", 32'(last4), 32'h22);
        step4(1'b1, 8'hE0, 1'b0, 16'h0001, 1'b0);
        step4(1'b1, 8'h1D, 1'b0, 16'h0001, 1'b0);
        check("last_ext", 32'(last4), 32'h1D);
        step4(1'b1, 8'hE0, 1'b0, 16'h0001, 1'b0);
        step4(1'b1, 8'hF0, 1'b0, 16'h0001, 1'b0);
        step4(1'b1, 8'h1B, 1'b0, 16'h0001, 1'b0);
        check("last_ext_break", 32'(last4), 32'h1D);

        // Clear keeps high score, drops new_high
        step4(1'b0, 8'h00, 1'b1, 16'h0000, 1'b1);
        check("clr_high", 32'(high4), 32'h1);
        check("clr_new_high", 32'(nh4), 32'h0);
        step4(1'b1, 8'h1D, 1'b0, 16'h0001, 1'b1);
        @(negedge clk);
        check("eq_new_high", 32'(nh4), 32'h0);
        step4(1'b1, 8'h1D, 1'b0, 16'h0002, 1'b1);
        check("high_lag", 32'(high4), 32'h1);
        @(negedge clk);
        check("high_2", 32'(high4), 32'h2);
        check("new_high_2", 32'(nh4), 32'h1);
        step4(1'b1, 8'h1D, 1'b0, 16'h0003, 1'b1);
        step4(1'b1, 8'h1D, 1'b0, 16'h0004, 1'b1);
        check("high_3", 32'(high4), 32'h3);
        @(negedge clk);
        check("high_4", 32'(high4), 32'h4);
        step4(1'b1, 8'h1B, 1'b0, 16'h0003, 1'b1);
        step4(1'b1, 8'h1B, 1'b0, 16'h0002, 1'b1);
        @(negedge clk);
        check("high_kept", 32'(high4), 32'h4);
        check("sat4_low", 32'(sat4), 32'h0);

        for (int i = 3; i <= 7; i++) step4(1'b1, 8'h1D, 1'b0, 16'(i), 1'b1);
        @(negedge clk);
        check("high_7", 32'(high4), 32'h7);

        // Clear wins over a scoring byte in the same cycle
        step4(1'b1, 8'h1D, 1'b1, 16'h0000, 1'b1);
        check("clr_key_last", 32'(last4), 32'h1D);
        @(negedge clk);
        check("clr_key_high", 32'(high4), 32'h7);
        step4(1'b0, 8'h00, 1'b1, 16'h0000, 1'b0);
        step4(1'b1, 8'h1B, 1'b0, 16'h0000, 1'b0);

        // Disabled scoring still parses
        step4(1'b1, 8'h22, 1'b0, 16'h0000, 1'b0);
        enable = 1'b0;
        step4(1'b1, 8'h1D, 1'b0, 16'h0000, 1'b0);
        check("dis_last", 32'(last4), 32'h1D);
        enable = 1'b1;

        // Reset discards pending prefixes
        step4(1'b1, 8'hF0, 1'b0, 16'h0000, 1'b0);
        do_reset();
        check("mid_rst_last", 32'(last4), 32'h0);
        check("mid_rst_high", 32'(high4), 32'h0);
        step4(1'b1, 8'h1D, 1'b0, 16'h0001, 1'b1);
        step4(1'b1, 8'hE0, 1'b0, 16'h0001, 1'b0);
        do_reset();
        step4(1'b1, 8'h1D, 1'b0, 16'h0001, 1'b1);

        // Two-digit, STEP=5: carry across digits then saturation
        do_reset();
        for (int i = 1; i <= 19; i++) begin
            e = i * 5;
            step2(8'h1D, {4'(e / 10), 4'(e % 10)}, 1'b1);
        end
        check("sat2_95", 32'(sat2), 32'h0);
        step2(8'h1D, 8'h99, 1'b1);
        check("sat2_99", 32'(sat2), 32'h1);
        step2(8'h1D, 8'h99, 1'b0);
        check("sat2_hold", 32'(sat2), 32'h1);
        step2(8'h1B, 8'h94, 1'b1);
        check("sat2_off", 32'(sat2), 32'h0);
        @(negedge clk);
        check("high2", 32'(high2), 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits in score and high score, legal range 1-8.
REQ-002 Parameter INC_CODE, default 8'h1D: non-extended make code that adds STEP points.
REQ-003 Parameter DEC_CODE, default 8'h1B: non-extended make code that subtracts STEP points.
REQ-004 Parameter STEP, default 1: points per scoring event, legal range 1-9.
REQ-005 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high; sampled on the CLOCK_50 rising edge.
REQ-007 key_data  in  8  PS/2 scan-code byte from the PS2 controller.
REQ-008 key_valid  in  1  one-cycle strobe qualifying key_data.
REQ-009 enable  in  1  scoring enabled; when low, bytes are still parsed but the score is frozen.
REQ-010 clear_score  in  1  zeroes score_bcd only; high_bcd is kept.
REQ-011 score_bcd  out  4*DIGITS  current score, packed BCD, digit 0 in [3:0].
REQ-012 high_bcd  out  4*DIGITS  highest score since reset, packed BCD.
REQ-013 last_make  out  8  most recent make code, extended or not.
REQ-014 score_pulse  out  1  one-cycle pulse on every actual change of score_bcd.
REQ-015 new_high  out  1  sticky flag: high_bcd raised since last clear_score.
REQ-016 sat  out  1  high while score_bcd is all nines.

Function
REQ-017 The parser FSM shall have four states: IDLE, BREAK, EXT, EXT_BREAK; it advances only on key_valid.
REQ-018 In IDLE: F0 goes to BREAK, E0 goes to EXT, any other byte is a plain make code and the FSM stays in IDLE.
REQ-019 In BREAK: any byte is discarded and the FSM returns to IDLE.
REQ-020 In EXT: F0 goes to EXT_BREAK, any other byte is an extended make code and the FSM returns to IDLE.
REQ-021 In EXT_BREAK: any byte is discarded and the FSM returns to IDLE.
REQ-022 Every make code, plain or extended, shall load last_make in the cycle after key_valid.
REQ-023 Only plain make codes equal to INC_CODE or DEC_CODE, with enable high, shall score; extended codes never score.
REQ-024 Latency: a key_valid on edge n shall update score_bcd and score_pulse at edge n+1.
REQ-025 Increment shall be a BCD add of STEP with carry across all digits; a result above all nines shall saturate to all nines.
REQ-026 Decrement shall be a BCD subtract of STEP with borrow; a result below zero shall floor at zero.
REQ-027 score_pulse shall stay low when a saturated increment or zero-floor decrement leaves the value unchanged.
REQ-028 Every score_bcd digit shall always be in the range 0-9.
REQ-029 When registered score_bcd exceeds high_bcd, high_bcd shall load score_bcd one cycle later and set new_high in that same cycle.
REQ-030 If clear_score and a scoring key_valid occur in the same cycle, clear wins; the byte still advances the FSM and updates last_make.
REQ-031 clear_score shall zero score_bcd and new_high next edge; score_pulse fires only if score_bcd was nonzero.
REQ-032 sat shall be combinational from score_bcd.

Reset
REQ-033 reset shall take priority over all inputs.
REQ-034 On reset: FSM goes to IDLE; score_bcd, high_bcd and last_make go to 0; score_pulse and new_high go to 0.
REQ-035 A reset asserted mid-sequence (after F0 or E0) shall discard the pending prefix; the next byte is parsed from IDLE.

Verification
REQ-036 Bytes 1D, F0, 1D after reset -> score_bcd=0001 with one score_pulse; last_make=1D; the break byte does not score.
REQ-037 Bytes E0, 1D -> last_make=1D, score unchanged, no pulse; E0, F0, 1D -> all discarded.
REQ-038 DIGITS=2, STEP=5, score 95, 1D -> score 99, sat=1; a further 1D -> score 99, no score_pulse.
REQ-039 Score 0003, 1D -> 0004, then high_bcd=0004 and new_high=1 one cycle later; 1B twice -> 0002, high_bcd stays 0004.
REQ-040 clear_score and key_valid=1D in the same cycle at score 0007 -> score 0000, last_make=1D, high_bcd unchanged.
REQ-041 enable=0, 1D -> last_make=1D, score unchanged; reset after F0 then 1D -> score 0001.
